// File: rtl/rf_mp_sb_pkg.sv
// Shared definitions for the multi-port register file: default geometry and
// the encoding of the zero-init sequencer states.
package rf_mp_sb_pkg;

   localparam int RF_XLEN = 64;
   localparam int RF_NREG = 32;
   localparam int RF_NRD  = 4;
   localparam int RF_NWR  = 2;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_e;

   // True when an enabled write port targets a real (non-x0) register.
   function automatic logic rf_wr_hits(input logic wen, input logic [31:0] dst,
                                       input logic [31:0] reg_idx);
      return wen && (dst != 32'd0) && (dst == reg_idx);
   endfunction

endpackage

// File: rtl/rf_mp_sb_scoreboard.sv
// Per-register busy scoreboard: one bit per architectural register, set by
// issue and cleared by writeback, with NRD combinational lookups.
module rf_scoreboard #(
   parameter int  NREG   = 32,
   parameter int  NRD    = 4,
   parameter int  BYPASS = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREG-1:0]   clr_i,
   input  logic              set_i,
   input  logic [AW-1:0]     set_dst_i,
   input  logic [NRD*AW-1:0] rsrc_i,
   output logic [NRD-1:0]    rbusy_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // A set in the same cycle as a clear wins: it belongs to a newer producer.
   always_comb begin
      busy_d = busy_q & ~clr_i;
      if (set_i && (set_dst_i != '0)) begin
         busy_d[set_dst_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Same-cycle clears are forwarded when bypassing; same-cycle sets never are.
   always_comb begin
      rbusy_o = '0;
      for (int i = 0; i < NRD; i++) begin
         if (BYPASS != 0) begin
            rbusy_o[i] = busy_q[rsrc_i[i*AW +: AW]] && !clr_i[rsrc_i[i*AW +: AW]];
         end else begin
            rbusy_o[i] = busy_q[rsrc_i[i*AW +: AW]];
         end
      end
   end

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port integer register file with write-to-read bypass, busy scoreboard
// and a post-reset sweep that zeroes every register before reporting ready.
module rf_mp_sb
   import rf_mp_sb_pkg::*;
#(
   parameter int  XLEN   = RF_XLEN,
   parameter int  NREG   = RF_NREG,
   parameter int  NRD    = RF_NRD,
   parameter int  NWR    = RF_NWR,
   parameter int  BYPASS = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                rf_ready,
   input  logic [NRD*AW-1:0]   rf_rsrc,
   output logic [NRD*XLEN-1:0] rf_rdata,
   output logic [NRD-1:0]      rf_rbusy,
   input  logic [NWR-1:0]      rf_wen,
   input  logic [NWR*AW-1:0]   rf_wdst,
   input  logic [NWR*XLEN-1:0] rf_wdata,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_dst
);

   rf_state_e       state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [XLEN-1:0] regs_q [NREG];
   logic            run;
   logic [NREG-1:0] wclr;
   logic [NRD-1:0]  sbRbusy;

   assign run      = (state_q == RF_RUN);
   assign rf_ready = run;

   // The sweep starts at x1 (x0 is never stored) and ends after writing NREG-1.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         RF_INIT: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(NREG - 1)) begin
               state_d = RF_RUN;
            end
         end
         RF_RUN: begin
            state_d = RF_RUN;
         end
         default: begin
            state_d = RF_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RF_INIT;
         ptr_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Later write ports are applied last so the highest index wins on collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            regs_q[ptr_q] <= '0;
         end else begin
            for (int w = 0; w < NWR; w++) begin
               if (rf_wen[w] && (rf_wdst[w*AW +: AW] != '0)) begin
                  regs_q[rf_wdst[w*AW +: AW]] <= rf_wdata[w*XLEN +: XLEN];
               end
            end
         end
      end
   end

   always_comb begin
      wclr = '0;
      if (run) begin
         for (int r = 1; r < NREG; r++) begin
            for (int w = 0; w < NWR; w++) begin
               if (rf_wr_hits(rf_wen[w], 32'(rf_wdst[w*AW +: AW]), 32'(r))) begin
                  wclr[r] = 1'b1;
               end
            end
         end
      end
   end

   rf_scoreboard #(
      .NREG   (NREG),
      .NRD    (NRD),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wclr),
      .set_i     (sb_set && run),
      .set_dst_i (sb_dst),
      .rsrc_i    (rf_rsrc),
      .rbusy_o   (sbRbusy)
   );

   assign rf_rbusy = run ? sbRbusy : '0;

   // x0 and the whole sweep window read as zero regardless of pending writes.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   rdAddr;
      logic [XLEN-1:0] rdVal;

      assign rdAddr = rf_rsrc[i*AW +: AW];

      always_comb begin
         rdVal = regs_q[rdAddr];
         if (BYPASS != 0) begin
            for (int w = 0; w < NWR; w++) begin
               if (rf_wen[w] && (rf_wdst[w*AW +: AW] == rdAddr)) begin
                  rdVal = rf_wdata[w*XLEN +: XLEN];
               end
            end
         end
         if (!run || (rdAddr == '0)) begin
            rdVal = '0;
         end
      end

      assign rf_rdata[i*XLEN +: XLEN] = rdVal;
   end

endmodule

// File: tb/tb_rf_mp_sb.sv
// Directed bench for rf_mp_sb (default parameters, BYPASS=1): reset sweep,
// bypass, write collisions, scoreboard set/clear, x0 handling and re-reset.
module tb_rf_mp_sb;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRD  = 4;
   localparam int NWR  = 2;
   localparam int AW   = 5;

   logic                clk;
   logic                rst;
   logic                rf_ready;
   logic [NRD*AW-1:0]   rf_rsrc;
   logic [NRD*XLEN-1:0] rf_rdata;
   logic [NRD-1:0]      rf_rbusy;
   logic [NWR-1:0]      rf_wen;
   logic [NWR*AW-1:0]   rf_wdst;
   logic [NWR*XLEN-1:0] rf_wdata;
   logic                sb_set;
   logic [AW-1:0]       sb_dst;

   int checks = 0;
   int errors = 0;
   int cnt;

   rf_mp_sb #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .NRD    (NRD),
      .NWR    (NWR),
      .BYPASS (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rf_ready (rf_ready),
      .rf_rsrc  (rf_rsrc),
      .rf_rdata (rf_rdata),
      .rf_rbusy (rf_rbusy),
      .rf_wen   (rf_wen),
      .rf_wdst  (rf_wdst),
      .rf_wdata (rf_wdata),
      .sb_set   (sb_set),
      .sb_dst   (sb_dst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rf_wen   = '0;
      rf_wdst  = '0;
      rf_wdata = '0;
      sb_set   = 1'b0;
      sb_dst   = '0;
   endtask

   task automatic applyStimulus(input int port, input logic [AW-1:0] dst, input logic [XLEN-1:0] data);
      rf_wen[port]                 = 1'b1;
      rf_wdst[port*AW +: AW]       = dst;
      rf_wdata[port*XLEN +: XLEN]  = data;
   endtask

   task automatic setRead(input int port, input logic [AW-1:0] addr);
      rf_rsrc[port*AW +: AW] = addr;
   endtask

   function automatic logic [XLEN-1:0] rdataOf(input int port);
      return rf_rdata[port*XLEN +: XLEN];
   endfunction

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      rf_rsrc = '0;
      idle();
      tick();
      rst = 1'b0;

      // 1: sweep length, gated outputs, inputs ignored during INIT
      setRead(0, 5'd5);
      setRead(1, 5'd9);
      setRead(2, 5'd3);
      setRead(3, 5'd31);
      applyStimulus(0, 5'd5, 64'hFF);
      sb_set = 1'b1;
      sb_dst = 5'd9;
      for (int i = 0; i < 31; i++) begin
         #1;
         checkOutput("init_ready_low", 64'(rf_ready), 64'd0);
         if (i == 0 || i == 30) begin
            checkOutput("init_rdata0", rdataOf(0), 64'd0);
            checkOutput("init_rbusy", 64'(rf_rbusy), 64'd0);
         end
         tick();
      end
      checkOutput("ready_after_sweep", 64'(rf_ready), 64'd1);
      idle();
      #1;
      checkOutput("swept_x5", rdataOf(0), 64'd0);
      checkOutput("swept_x31", rdataOf(3), 64'd0);
      checkOutput("busy9_not_set_in_init", 64'(rf_rbusy), 64'd0);

      // 2: same-cycle bypass, then array value
      setRead(0, 5'd5);
      applyStimulus(0, 5'd5, 64'hDEAD_BEEF);
      #1;
      checkOutput("bypass_x5", rdataOf(0), 64'hDEAD_BEEF);
      tick();
      idle();
      #1;
      checkOutput("array_x5", rdataOf(0), 64'hDEAD_BEEF);

      // 3: collision on x7, highest port wins; distinct targets both land
      setRead(1, 5'd7);
      applyStimulus(0, 5'd7, 64'h11);
      applyStimulus(1, 5'd7, 64'h22);
      #1;
      checkOutput("collide_bypass_x7", rdataOf(1), 64'h22);
      tick();
      idle();
      #1;
      checkOutput("collide_array_x7", rdataOf(1), 64'h22);
      setRead(2, 5'd10);
      setRead(3, 5'd11);
      applyStimulus(0, 5'd10, 64'h1010);
      applyStimulus(1, 5'd11, 64'h1111);
      tick();
      idle();
      #1;
      checkOutput("dual_write_x10", rdataOf(2), 64'h1010);
      checkOutput("dual_write_x11", rdataOf(3), 64'h1111);

      // 4: scoreboard set, set-beats-clear, plain clear
      setRead(2, 5'd9);
      sb_set = 1'b1;
      sb_dst = 5'd9;
      #1;
      checkOutput("set_not_forwarded", 64'(rf_rbusy[2]), 64'd0);
      tick();
      idle();
      #1;
      checkOutput("busy9_set", 64'(rf_rbusy[2]), 64'd1);
      applyStimulus(0, 5'd9, 64'h99);
      sb_set = 1'b1;
      sb_dst = 5'd9;
      #1;
      checkOutput("set_clr_same_masked", 64'(rf_rbusy[2]), 64'd0);
      checkOutput("set_clr_bypass_data", rdataOf(2), 64'h99);
      tick();
      idle();
      #1;
      checkOutput("set_wins_busy9", 64'(rf_rbusy[2]), 64'd1);
      applyStimulus(1, 5'd9, 64'hAB);
      #1;
      checkOutput("clear_forwarded", 64'(rf_rbusy[2]), 64'd0);
      tick();
      idle();
      #1;
      checkOutput("busy9_cleared", 64'(rf_rbusy[2]), 64'd0);
      checkOutput("x9_data", rdataOf(2), 64'hAB);

      // 5: x0 is never written and never busy
      setRead(3, 5'd0);
      applyStimulus(0, 5'd0, 64'hFF);
      applyStimulus(1, 5'd0, 64'hFF);
      sb_set = 1'b1;
      sb_dst = 5'd0;
      #1;
      checkOutput("x0_bypass", rdataOf(3), 64'd0);
      checkOutput("x0_busy_now", 64'(rf_rbusy[3]), 64'd0);
      tick();
      idle();
      #1;
      checkOutput("x0_array", rdataOf(3), 64'd0);
      checkOutput("x0_busy_next", 64'(rf_rbusy[3]), 64'd0);

      // 6: reset in RUN and again mid-sweep
      setRead(0, 5'd3);
      setRead(1, 5'd12);
      setRead(2, 5'd13);
      applyStimulus(0, 5'd3, 64'h5);
      tick();
      idle();
      sb_set = 1'b1;
      sb_dst = 5'd12;
      tick();
      idle();
      #1;
      checkOutput("x3_before_reset", rdataOf(0), 64'h5);
      checkOutput("busy12_before_reset", 64'(rf_rbusy[1]), 64'd1);
      rst = 1'b1;
      applyStimulus(0, 5'd3, 64'h77);
      sb_set = 1'b1;
      sb_dst = 5'd13;
      tick();
      rst = 1'b0;
      idle();
      #1;
      checkOutput("ready_dropped", 64'(rf_ready), 64'd0);
      checkOutput("x3_gated_in_init", rdataOf(0), 64'd0);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cnt = 0;
      while (!rf_ready && cnt < 40) begin
         tick();
         cnt++;
      end
      checkOutput("restart_sweep_len", 64'(cnt), 64'd31);
      #1;
      checkOutput("x3_zeroed", rdataOf(0), 64'd0);
      checkOutput("busy_cleared", 64'(rf_rbusy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
